// File: rtl/beacon_rx.sv
// Carrier-burst detector: counts rx_in edges per fixed window and reports each
// burst once with the timestamp of its first active window and its length in windows.
module beacon_rx #(
  parameter int WIN_LOG2    = 3,
  parameter int THRESH      = 2,
  parameter int MIN_WINDOWS = 4,
  parameter int HOLDOFF     = 64,
  parameter int TS_W        = 16,
  parameter int LEN_W       = 11
) (
  input  logic             xtal_in,
  input  logic             resetn,
  input  logic             rx_in,
  input  logic             rx_en,
  output logic             rx_valid,
  output logic [TS_W-1:0]  rx_ts,
  output logic [LEN_W-1:0] rx_len,
  output logic             rx_busy
);

  localparam int ECNT_W = $clog2(THRESH + 2);
  localparam int HCNT_W = $clog2(HOLDOFF + 1);
  localparam logic [ECNT_W-1:0] THRESH_E = ECNT_W'(THRESH);

  typedef enum logic [2:0] {S_IDLE, S_DETECT, S_ACTIVE, S_REPORT, S_HOLDOFF} state_t;

  function automatic logic [LEN_W-1:0] sat_inc_len(input logic [LEN_W-1:0] v);
    return (v == '1) ? v : v + LEN_W'(1);
  endfunction

  state_t              r_state;
  logic                r_s1, r_s2, r_s3;
  logic [TS_W-1:0]     r_ts;
  logic [TS_W-1:0]     r_win_ts;
  logic [TS_W-1:0]     r_start_ts;
  logic [WIN_LOG2-1:0] r_wcnt;
  logic [ECNT_W-1:0]   r_ecnt;
  logic [LEN_W-1:0]    r_len;
  logic [HCNT_W-1:0]   r_hcnt;

  logic                w_edge;
  logic                w_win_end;
  logic [ECNT_W:0]     w_ecnt_sum;
  logic                w_active;
  logic [LEN_W-1:0]    w_len_inc;

  assign w_edge     = r_s2 ^ r_s3;
  assign w_win_end  = (r_wcnt == '1);
  assign w_ecnt_sum = {1'b0, r_ecnt} + {{ECNT_W{1'b0}}, w_edge};
  assign w_active   = (w_ecnt_sum >= {1'b0, THRESH_E});
  assign w_len_inc  = sat_inc_len(r_len);
  assign rx_busy    = (r_state != S_IDLE);

  // Stage 0: synchronizer, timestamp, window framing and edge counting
  always_ff @(posedge xtal_in) begin
    if (!resetn) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_s3     <= 1'b0;
      r_ts     <= '0;
      r_wcnt   <= '0;
      r_ecnt   <= '0;
      r_win_ts <= '0;
    end else begin
      r_s1   <= rx_in;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_ts   <= r_ts + TS_W'(1);
      r_wcnt <= r_wcnt + WIN_LOG2'(1);
      if (r_wcnt == '0)
        r_win_ts <= r_ts;
      if (w_win_end)
        r_ecnt <= '0;
      else if (w_edge && (r_ecnt < THRESH_E))
        r_ecnt <= r_ecnt + ECNT_W'(1);
    end
  end

  // Stage 1: burst FSM with registered report outputs
  always_ff @(posedge xtal_in) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_start_ts <= '0;
      r_len      <= '0;
      r_hcnt     <= '0;
      rx_valid   <= 1'b0;
      rx_ts      <= '0;
      rx_len     <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_win_end && rx_en && w_active) begin
            r_state    <= S_DETECT;
            r_start_ts <= r_win_ts;
            r_len      <= LEN_W'(1);
          end
        end
        S_DETECT: begin
          if (!rx_en) begin
            r_state <= S_IDLE;
          end else if (w_win_end) begin
            if (w_active) begin
              r_len <= w_len_inc;
              if (w_len_inc == LEN_W'(MIN_WINDOWS))
                r_state <= S_ACTIVE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_ACTIVE: begin
          if (!rx_en) begin
            r_state <= S_IDLE;
          end else if (w_win_end) begin
            if (w_active) begin
              r_len <= w_len_inc;
            end else begin
              r_state  <= S_REPORT;
              rx_valid <= 1'b1;
              rx_ts    <= r_start_ts;
              rx_len   <= r_len;
            end
          end
        end
        S_REPORT: begin
          r_state <= S_HOLDOFF;
          r_hcnt  <= '0;
        end
        S_HOLDOFF: begin
          // windows closing here are deliberately ignored
          if (!rx_en || (r_hcnt == HCNT_W'(HOLDOFF - 1)))
            r_state <= S_IDLE;
          else
            r_hcnt <= r_hcnt + HCNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beacon_rx.sv
// Directed bench for beacon_rx: table of burst shapes plus hand-written
// holdoff and abort sequences; cycle numbers follow the DUT timestamp.
module tb_beacon_rx;
  localparam int TS_W  = 16;
  localparam int LEN_W = 11;

  logic             xtal_in = 1'b0;
  logic             resetn  = 1'b0;
  logic             rx_in   = 1'b0;
  logic             rx_en   = 1'b0;
  logic             rx_valid;
  logic [TS_W-1:0]  rx_ts;
  logic [LEN_W-1:0] rx_len;
  logic             rx_busy;

  beacon_rx dut (
    .xtal_in (xtal_in),
    .resetn  (resetn),
    .rx_in   (rx_in),
    .rx_en   (rx_en),
    .rx_valid(rx_valid),
    .rx_ts   (rx_ts),
    .rx_len  (rx_len),
    .rx_busy (rx_busy)
  );

  always #5 xtal_in = ~xtal_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference timestamp: 0 in the first cycle after reset release
  always @(posedge xtal_in) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  int n_rep, busy_first, busy_last, busy_cnt;
  int rep_ts[4], rep_len[4], rep_cyc[4];

  always @(negedge xtal_in) begin
    if (!resetn) begin
      n_rep      = 0;
      busy_first = -1;
      busy_last  = -1;
      busy_cnt   = 0;
    end else begin
      if (rx_valid) begin
        if (n_rep < 4) begin
          rep_ts[n_rep]  = int'(rx_ts);
          rep_len[n_rep] = int'(rx_len);
          rep_cyc[n_rep] = cyc;
        end
        n_rep = n_rep + 1;
      end
      if (rx_busy) begin
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
        busy_cnt  = busy_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge xtal_in);
    #1;
  endtask

  task automatic to_cyc(input int t);
    int guard = 0;
    while (cyc != t && guard < 3000) begin
      step();
      guard++;
    end
    if (cyc != t) check("to_cyc_timeout", cyc, t);
  endtask

  task automatic do_reset(input logic en);
    resetn = 1'b0;
    rx_en  = en;
    for (int i = 0; i < 20; i++) begin
      rx_in = ~rx_in;
      step();
    end
    rx_in = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check($sformatf("%s_valid", tag), int'(rx_valid), 0);
    check($sformatf("%s_ts", tag),    int'(rx_ts),    0);
    check($sformatf("%s_len", tag),   int'(rx_len),   0);
    check($sformatf("%s_busy", tag),  int'(rx_busy),  0);
  endtask

  // toggle at cycle start+i for i%period==0; edge reaches the detector 2 cycles later
  task automatic burst(input int start, input int len, input int period);
    to_cyc(start);
    for (int i = 0; i < len; i++) begin
      if (i % period == 0) rx_in = ~rx_in;
      step();
    end
  endtask

  typedef struct {
    int   len;
    int   period;
    logic en;
    int   n_rep;
    int   ts;
    int   rlen;
    int   rep_cyc;
    int   busy_first;
    int   busy_last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{80,  1, 1'b1, 1, 40, 10, 128, 48, 192};  // nominal 10-window burst
    vecs[1] = '{24,  1, 1'b1, 0,  0,  0,  -1, 48,  71};  // 3 windows: dropped in DETECT
    vecs[2] = '{200, 8, 1'b1, 0,  0,  0,  -1, -1,  -1};  // one edge per window
    vecs[3] = '{48,  1, 1'b1, 1, 40,  6,  96, 48, 160};
    vecs[4] = '{32,  1, 1'b1, 1, 40,  4,  80, 48, 144};  // exactly MIN_WINDOWS
    vecs[5] = '{80,  4, 1'b1, 1, 40, 10, 128, 48, 192};  // exactly THRESH edges/window
    vecs[6] = '{80,  1, 1'b0, 0,  0,  0,  -1, -1,  -1};  // detection disabled
    vecs[7] = '{40,  1, 1'b1, 1, 40,  5,  88, 48, 152};

    for (int v = 0; v < 8; v++) begin
      do_reset(vecs[v].en);
      check_outputs_zero($sformatf("v%0d_rst", v));
      burst(38, vecs[v].len, vecs[v].period);
      to_cyc(340);
      check($sformatf("v%0d_nrep", v), n_rep, vecs[v].n_rep);
      check($sformatf("v%0d_ts", v),   int'(rx_ts),  vecs[v].ts);
      check($sformatf("v%0d_len", v),  int'(rx_len), vecs[v].rlen);
      if (vecs[v].n_rep > 0)
        check($sformatf("v%0d_repcyc", v), rep_cyc[0], vecs[v].rep_cyc);
      check($sformatf("v%0d_busy_first", v), busy_first, vecs[v].busy_first);
      check($sformatf("v%0d_busy_last", v),  busy_last,  vecs[v].busy_last);
      check($sformatf("v%0d_busy_cnt", v), busy_cnt,
            (vecs[v].busy_first < 0) ? 0 : vecs[v].busy_last - vecs[v].busy_first + 1);
    end

    // Holdoff: A reported, B swallowed by holdoff, C reported from its own first window
    do_reset(1'b1);
    burst(38, 80, 1);
    burst(144, 32, 1);
    to_cyc(200);
    check("hold_nrep_mid", n_rep, 1);
    check("hold_ts_held", int'(rx_ts), 40);
    check("hold_len_held", int'(rx_len), 10);
    burst(228, 80, 1);
    to_cyc(400);
    check("hold_nrep", n_rep, 2);
    check("hold_a_cyc", rep_cyc[0], 128);
    check("hold_c_ts", rep_ts[1], 224);
    check("hold_c_len", rep_len[1], 11);
    check("hold_c_cyc", rep_cyc[1], 320);

    // Reset pulse in window 6 of an active burst
    do_reset(1'b1);
    burst(38, 44, 1);
    check("mrst_busy_before", int'(rx_busy), 1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    check("mrst_cyc", cyc, 0);
    check_outputs_zero("mrst_after");
    to_cyc(300);
    check("mrst_nrep", n_rep, 0);
    check("mrst_len", int'(rx_len), 0);

    // rx_en dropped in window 6: IDLE next cycle, never reported
    do_reset(1'b1);
    burst(38, 44, 1);
    rx_en = 1'b0;
    rx_in = ~rx_in;
    check("en_busy_before", int'(rx_busy), 1);
    step();
    check("en_busy_after", int'(rx_busy), 0);
    burst(83, 35, 1);
    to_cyc(200);
    rx_en = 1'b1;
    to_cyc(340);
    check("en_nrep", n_rep, 0);
    check("en_busy_last", busy_last, 82);
    check("en_len", int'(rx_len), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
